uart_rx_drain_ctrl: RTL and testbench

Controller that sequences the UART receive path downstream of the receiver's FIFO. It drains bytes from the RX FIFO (1-cycle read latency) and presents them on a valid/ready stream to the consumer. It also counts delivered bytes and overrun events (frame completed while FIFO full), and raises an idle-line pulse after a programmable number of silent character times. It sits between the RX FIFO and the packet/command layer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sat_cnt.sv | 41 ++++
 rtl/uart_rx_drain_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_drain_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// - drain_state_e : state encoding of the RX drain controller FSM
// - FRAME_BITS    : bits per character on the line (start + 8 data + stop)
// - tick_cnt_w()  : width of a counter that must hold values 0 .. ticks-1
//                   (used by the receiver and by the idle-line timer)
package uart_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } drain_state_e;

  // Never returns less than 1 so a degenerate count still yields a legal vector.
  function automatic int tick_cnt_w(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count cleared)
//   inc        : count one event this cycle
//   clr        : clear to zero; wins over a simultaneous inc
//   cnt        : current count, sticks at all-ones
module uart_sat_cnt
  import uart_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_drain_ctrl.sv
// RX drain controller: pulls bytes out of the receiver FIFO (1-cycle read
// latency) and offers them on a valid/ready stream, counts delivered bytes and
// overruns, and flags an idle line after IDLE_CHARS silent character times.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   baud_clk       : one-cycle baud tick strobe (B_TICK ticks per bit)
//   en             : allow new FIFO reads (a byte already fetched still completes)
//   rx_frame_done  : one-cycle strobe at the end of each received stop bit
//   ff_full        : RX FIFO full
//   ff_empty       : RX FIFO empty
//   ff_rd_en       : registered one-cycle FIFO read strobe
//   ff_rd_data     : FIFO data, valid the cycle after ff_rd_en is sampled
//   m_data/m_valid : output stream towards the consumer
//   m_ready        : consumer ready
//   idle_pulse     : one-cycle idle-line event
//   byte_cnt       : saturating count of completed handshakes
//   ovr_cnt        : saturating count of frames completed while FIFO full
//   clr_cnt        : synchronous clear of both counters
//   dbg_state      : current FSM state (drain_state_e encoding)
//
// Stream handshake: a byte transfers on every clk edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_data and m_valid hold
// unchanged until that transfer; m_valid never depends on m_ready.
module uart_rx_drain_ctrl
  import uart_pkg::*;
#(
  parameter int D_W        = 8,
  parameter int B_TICK     = 16,
  parameter int IDLE_CHARS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud_clk,
  input  logic             en,
  input  logic             rx_frame_done,
  input  logic             ff_full,
  input  logic             ff_empty,
  output logic             ff_rd_en,
  input  logic [D_W-1:0]   ff_rd_data,
  output logic [D_W-1:0]   m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             idle_pulse,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] ovr_cnt,
  input  logic             clr_cnt,
  output logic [1:0]       dbg_state
);

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  drain_state_e   state_q, state_d;
  logic           rd_en_q, rd_en_d;
  logic [D_W-1:0] m_data_q, m_data_d;
  logic           m_valid_q, m_valid_d;
  logic           xfer;

  assign xfer = m_valid_q && m_ready;

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;     // read strobe is only ever one cycle wide
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    case (state_q)
      S_IDLE: begin
        if (en && !ff_empty) begin
          rd_en_d = 1'b1;
          state_d = S_RD;
        end
      end
      // FIFO samples rd_en at the end of this state.
      S_RD: begin
        state_d = S_LATCH;
      end
      // FIFO data is on ff_rd_data during this state.
      S_LATCH: begin
        m_data_d  = ff_rd_data;
        m_valid_d = 1'b1;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (xfer) begin
          m_valid_d = 1'b0;
          // Chain straight into the next read to reach one byte per 3 cycles.
          if (en && !ff_empty) begin
            rd_en_d = 1'b1;
            state_d = S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign ff_rd_en  = rd_en_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  uart_sat_cnt #(.W(CNT_W)) u_byte_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (xfer),
    .clr   (clr_cnt),
    .cnt   (byte_cnt)
  );

  uart_sat_cnt #(.W(CNT_W)) u_ovr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rx_frame_done && ff_full),
    .clr   (clr_cnt),
    .cnt   (ovr_cnt)
  );

  // ---------------------------------------------------------------------------
  // Idle-line timer: counts baud ticks since the last completed frame and
  // fires once when IDLE_CHARS whole characters have passed in silence.
  // ---------------------------------------------------------------------------
  generate
    if (IDLE_CHARS == 0) begin : g_no_idle
      assign idle_pulse = 1'b0;
    end else begin : g_idle
      localparam int IDLE_TICKS = IDLE_CHARS * FRAME_BITS * B_TICK;
      localparam int TMR_W      = tick_cnt_w(IDLE_TICKS);
      localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_TICKS - 1);

      logic [TMR_W-1:0] tmr_q, tmr_d;
      logic             armed_q, armed_d;
      logic             pulse_q, pulse_d;

      always_comb begin
        tmr_d   = tmr_q;
        armed_d = armed_q;
        pulse_d = 1'b0;
        if (rx_frame_done) begin
          // A new frame always restarts the silence window, even on a tick.
          tmr_d   = '0;
          armed_d = 1'b1;
        end else if (armed_q && baud_clk) begin
          if (tmr_q == IDLE_LAST) begin
            tmr_d   = '0;
            armed_d = 1'b0;
            pulse_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tmr_q   <= '0;
          armed_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          tmr_q   <= tmr_d;
          armed_q <= armed_d;
          pulse_q <= pulse_d;
        end
      end

      assign idle_pulse = pulse_q;
    end
  endgenerate

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Bench for uart_rx_drain_ctrl: a queue-based FIFO emulation, a behavioural
// reference model stepped once per clock, per-cycle comparison of every output,
// directed scenarios with literal expectations, then a randomized phase.
module tb_uart_rx_drain_ctrl;

  localparam int D_W        = 8;
  localparam int B_TICK     = 16;
  localparam int IDLE_CHARS = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int IDLE_TICKS = IDLE_CHARS * 10 * B_TICK;

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             baud_clk = 1'b0;
  logic             en = 1'b0;
  logic             rx_frame_done = 1'b0;
  logic             ff_full = 1'b0;
  logic             ff_empty = 1'b1;
  logic [D_W-1:0]   ff_rd_data = '0;
  logic             m_ready = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             ff_rd_en;
  logic [D_W-1:0]   m_data;
  logic             m_valid;
  logic             idle_pulse;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] ovr_cnt;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  uart_rx_drain_ctrl #(
    .D_W(D_W), .B_TICK(B_TICK), .IDLE_CHARS(IDLE_CHARS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .en(en),
    .rx_frame_done(rx_frame_done), .ff_full(ff_full), .ff_empty(ff_empty),
    .ff_rd_en(ff_rd_en), .ff_rd_data(ff_rd_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .idle_pulse(idle_pulse),
    .byte_cnt(byte_cnt), .ovr_cnt(ovr_cnt), .clr_cnt(clr_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;

  logic [D_W-1:0] fifo_q[$];   // contents of the emulated RX FIFO
  logic [D_W-1:0] exp_q[$];    // bytes read out of the FIFO, awaiting delivery
  logic [D_W-1:0] seen_q[$];   // bytes actually handed over by the DUT
  bit             rd_pend;
  logic [D_W-1:0] rd_word;
  bit             auto_fill = 1'b0;
  int             rd_pulses, valid_cycles, pulses;
  bit             prev_val;
  logic [D_W-1:0] prev_data;

  // reference model state
  bit             e_rd, e_val, e_pulse, armed;
  logic [D_W-1:0] e_data;
  int             fetch_age;   // 0: nothing in flight, 1: read strobe out, 2: data due
  int             e_bcnt, e_ocnt, ticks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_rd = 0; e_val = 0; e_pulse = 0; armed = 0; e_data = '0;
    fetch_age = 0; e_bcnt = 0; e_ocnt = 0; ticks = 0;
    exp_q.delete(); seen_q.delete();
    rd_pend = 0; prev_val = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    bit hs;
    hs = e_val && m_ready;
    if (clr_cnt) e_bcnt = 0;
    else if (hs && e_bcnt < CNT_MAX) e_bcnt++;
    if (clr_cnt) e_ocnt = 0;
    else if (rx_frame_done && ff_full && e_ocnt < CNT_MAX) e_ocnt++;

    e_pulse = 0;
    if (rx_frame_done) begin
      armed = 1; ticks = 0;
    end else if (armed && baud_clk) begin
      ticks++;
      if (ticks == IDLE_TICKS) begin
        e_pulse = 1; armed = 0;
      end
    end

    e_rd = 0;
    if (fetch_age == 1) begin
      fetch_age = 2;
    end else if (fetch_age == 2) begin
      fetch_age = 0;
      e_val = 1;
      e_data = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    end else if (!e_val || hs) begin
      e_val = 0;
      if (en && !ff_empty) begin
        e_rd = 1; fetch_age = 1;
      end
    end
  endtask

  // FIFO emulation: data appears only in the cycle after the read is sampled.
  task automatic fifo_drive();
    if (rd_pend) begin
      ff_rd_data = rd_word; rd_pend = 0;
    end else begin
      ff_rd_data = D_W'($urandom);
    end
    if (ff_rd_en) begin
      rd_pulses++;
      chk("fifo_not_empty_on_read", 32'(fifo_q.size() > 0), 32'd1);
      if (fifo_q.size() > 0) begin
        rd_word = fifo_q.pop_front();
        exp_q.push_back(rd_word);
        rd_pend = 1;
      end
    end
    if (auto_fill && fifo_q.size() < 8 && $urandom_range(0, 2) == 0)
      fifo_q.push_back(D_W'($urandom));
    ff_empty = (fifo_q.size() == 0);
  endtask

  // One clock: sample at negedge, step model, compare all outputs, drive FIFO.
  task automatic cycle();
    @(negedge clk);
    if (prev_val && m_ready) seen_q.push_back(prev_data);
    model_step();
    chk("m_valid", m_valid, e_val);
    if (e_val) chk("m_data", m_data, e_data);
    chk("ff_rd_en", ff_rd_en, e_rd);
    chk("idle_pulse", idle_pulse, e_pulse);
    chk("byte_cnt", byte_cnt, e_bcnt);
    chk("ovr_cnt", ovr_cnt, e_ocnt);
    prev_val = m_valid; prev_data = m_data;
    if (m_valid) valid_cycles++;
    if (idle_pulse) pulses++;
    fifo_drive();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int first_valid;
    int p0;

    // Reset values, with the FIFO already holding two bytes.
    model_reset();
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h3C);
    ff_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_ff_rd_en", ff_rd_en, 1'b0);
    chk("rst_idle_pulse", idle_pulse, 1'b0);
    chk("rst_byte_cnt", byte_cnt, 4'd0);
    chk("rst_ovr_cnt", ovr_cnt, 4'd0);

    // Drain two bytes with the consumer always ready.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; m_ready = 1'b1;
    rd_pulses = 0; valid_cycles = 0; first_valid = -1;
    for (int i = 1; i <= 14; i++) begin
      cycle();
      if (m_valid && first_valid < 0) first_valid = i;
    end
    chk("drain_latency", first_valid, 3);
    chk("drain_rd_pulses", rd_pulses, 2);
    chk("drain_valid_cycles", valid_cycles, 2);
    chk("drain_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("drain_byte0", seen_q[0], 8'hA5);
      chk("drain_byte1", seen_q[1], 8'h3C);
    end
    chk("drain_byte_cnt", byte_cnt, 4'd2);

    // Backpressure: 0x55 must sit stable while the consumer stalls.
    m_ready = 1'b0;
    fifo_q.push_back(8'h55); ff_empty = 1'b0;
    for (int i = 0; i < 10 && !m_valid; i++) cycle();
    chk("bp_valid_seen", m_valid, 1'b1);
    fifo_q.push_back(8'h66); ff_empty = 1'b0;
    p0 = rd_pulses;
    repeat (20) begin
      cycle();
      chk("bp_valid_hold", m_valid, 1'b1);
      chk("bp_data_hold", m_data, 8'h55);
    end
    chk("bp_no_reads", rd_pulses, p0);
    m_ready = 1'b1;
    cycle();
    chk("bp_release_cnt", byte_cnt, 4'd3);
    repeat (6) cycle();
    chk("bp_next_cnt", byte_cnt, 4'd4);

    // Asynchronous reset while a byte is held.
    m_ready = 1'b0;
    fifo_q.push_back(8'h77); ff_empty = 1'b0;
    for (int i = 0; i < 10 && !m_valid; i++) cycle();
    chk("hold_before_rst", m_valid, 1'b1);
    fifo_q.push_back(8'h88); ff_empty = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_ff_rd_en", ff_rd_en, 1'b0);
    chk("arst_byte_cnt", byte_cnt, 4'd0);
    chk("arst_ovr_cnt", ovr_cnt, 4'd0);
    model_reset();
    fifo_q.delete(); fifo_q.push_back(8'h88); ff_empty = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1; m_ready = 1'b1;
    #1 chk("arst_first_cycle_rd", ff_rd_en, 1'b0);
    repeat (8) cycle();
    chk("arst_count", seen_q.size(), 1);
    if (seen_q.size() == 1) chk("arst_byte", seen_q[0], 8'h88);

    // Overrun counting and clear priority.
    clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
    ff_full = 1'b1;
    repeat (3) begin
      rx_frame_done = 1'b1; cycle();
      rx_frame_done = 1'b0; cycle();
    end
    chk("ovr_three", ovr_cnt, 4'd3);
    rx_frame_done = 1'b1; clr_cnt = 1'b1; cycle();
    rx_frame_done = 1'b0; clr_cnt = 1'b0; ff_full = 1'b0;
    chk("ovr_clr_prio", ovr_cnt, 4'd0);
    cycle();

    // Byte counter saturation.
    clr_cnt = 1'b1; cycle(); clr_cnt = 1'b0;
    for (int i = 0; i < 20; i++) fifo_q.push_back(D_W'($urandom));
    ff_empty = 1'b0; en = 1'b1; m_ready = 1'b1;
    repeat (80) cycle();
    chk("sat_handshakes", seen_q.size(), 21);
    chk("sat_byte_cnt", byte_cnt, 4'd15);

    // Idle line: 640 ticks after a frame, exactly once.
    en = 1'b0;
    rx_frame_done = 1'b1; cycle(); rx_frame_done = 1'b0;
    pulses = 0;
    for (int t = 0; t < IDLE_TICKS - 1; t++) begin
      baud_clk = 1'b1; cycle();
      baud_clk = 1'b0; cycle();
    end
    chk("idle_none_639", pulses, 0);
    baud_clk = 1'b1; cycle(); baud_clk = 1'b0;
    chk("idle_pulse_640", idle_pulse, 1'b1);
    cycle();
    chk("idle_pulse_width", idle_pulse, 1'b0);
    pulses = 0;
    repeat (2000) begin
      baud_clk = 1'b1; cycle();
      baud_clk = 1'b0; cycle();
    end
    chk("idle_no_repeat", pulses, 0);

    // Randomized traffic against the model.
    auto_fill = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      en            = ($urandom_range(0, 7) != 0);
      m_ready       = $urandom_range(0, 1);
      rx_frame_done = (i < 1500) ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 1999) == 0);
      ff_full       = $urandom_range(0, 1);
      baud_clk      = $urandom_range(0, 1);
      clr_cnt       = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
